// File: rtl/cypher_demux_1x4_if.sv
// Bus bundle for the 1-to-4 cypher nibble demultiplexer: one inbound
// valid/ready stream, four outbound first-word-fall-through channels,
// plus round-robin pointer and accepted-nibble counter observation.
interface cypher_demux_1x4_if;
  logic [3:0] cypher;
  logic [1:0] s;
  logic       auto_rr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cypher0;
  logic [3:0] cypher1;
  logic [3:0] cypher2;
  logic [3:0] cypher3;
  logic       valid0;
  logic       valid1;
  logic       valid2;
  logic       valid3;
  logic       ready0;
  logic       ready1;
  logic       ready2;
  logic       ready3;
  logic [1:0] rr_ptr;
  logic [7:0] total_count;

  // Producer / consumer side (drives the inbound stream and channel readies)
  modport master (
    output cypher, s, auto_rr, in_valid, ready0, ready1, ready2, ready3,
    input  in_ready, cypher0, cypher1, cypher2, cypher3,
    input  valid0, valid1, valid2, valid3, rr_ptr, total_count
  );

  // Demultiplexer side
  modport slave (
    input  cypher, s, auto_rr, in_valid, ready0, ready1, ready2, ready3,
    output in_ready, cypher0, cypher1, cypher2, cypher3,
    output valid0, valid1, valid2, valid3, rr_ptr, total_count
  );
endinterface

// File: rtl/cypher_demux_1x4.sv
// 1-to-4 cypher nibble demultiplexer. Each inbound nibble is steered to
// channel s (or the round-robin pointer when auto_rr=1) and buffered in a
// per-channel FWFT FIFO of DEPTH entries. in_ready reflects only the
// registered full flag of the selected channel, so a pop frees space one
// cycle later. Round robin stalls on a full channel rather than skipping.
module cypher_demux_1x4 #(
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  cypher_demux_1x4_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0] total_q, total_d;
  logic [1:0] dest;
  logic       accept;
  logic [3:0] ready_vec;
  logic [3:0] full_vec;
  logic [3:0] valid_vec;
  logic [3:0] head [4];

  assign ready_vec    = {bus.ready3, bus.ready2, bus.ready1, bus.ready0};
  assign dest         = bus.auto_rr ? rr_ptr_q : bus.s;
  assign bus.in_ready = ~full_vec[dest];
  assign accept       = bus.in_valid & ~full_vec[dest];

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hold_q, hold_d;
    logic          push, pop;

    assign push = accept && (dest == 2'(gi));
    assign pop  = (cnt_q != '0) && ready_vec[gi];

    // Channel FIFO next state; pointers wrap naturally at DEPTH (power of two)
    always_comb begin
      mem_d  = mem_q;
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      hold_d = hold_q;
      if (push) begin
        mem_d[wr_q] = bus.cypher;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) begin
        hold_d = mem_q[rd_q];
        rd_d   = rd_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    // Channel FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q  <= '{default: '0};
        rd_q   <= '0;
        wr_q   <= '0;
        cnt_q  <= '0;
        hold_q <= '0;
      end else begin
        mem_q  <= mem_d;
        rd_q   <= rd_d;
        wr_q   <= wr_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
      end
    end

    assign full_vec[gi]  = (cnt_q == CW'(DEPTH));
    assign valid_vec[gi] = (cnt_q != '0);
    // While empty, keep showing the last nibble that left the channel
    assign head[gi]      = valid_vec[gi] ? mem_q[rd_q] : hold_q;
  end

  // Round-robin pointer advances only on accepted nibbles in auto mode
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    total_d  = total_q;
    if (accept) begin
      total_d = total_q + 8'd1;
      if (bus.auto_rr) rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  // Pointer and accepted-nibble counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      total_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      total_q  <= total_d;
    end
  end

  assign bus.cypher0     = head[0];
  assign bus.cypher1     = head[1];
  assign bus.cypher2     = head[2];
  assign bus.cypher3     = head[3];
  assign bus.valid0      = valid_vec[0];
  assign bus.valid1      = valid_vec[1];
  assign bus.valid2      = valid_vec[2];
  assign bus.valid3      = valid_vec[3];
  assign bus.rr_ptr      = rr_ptr_q;
  assign bus.total_count = total_q;
endmodule

// File: tb/tb_cypher_demux_1x4.sv
// Randomized scoreboard bench for cypher_demux_1x4. The stimulus process
// pushes every accepted nibble into a per-channel expected queue; a
// separate monitor on the falling edge checks heads, valids, in_ready,
// rr_ptr and total_count and pops the queue whenever a channel is consumed.
module tb_cypher_demux_1x4;
  localparam int DEPTH  = 2;
  localparam int NCYC   = 1600;
  localparam int RST_AT = 1100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cypher_demux_1x4_if bus ();

  cypher_demux_1x4 #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] r_vec;
  assign bus.ready0 = r_vec[0];
  assign bus.ready1 = r_vec[1];
  assign bus.ready2 = r_vec[2];
  assign bus.ready3 = r_vec[3];

  logic [3:0] c_arr [4];
  logic [3:0] v_vec;
  assign c_arr[0] = bus.cypher0;
  assign c_arr[1] = bus.cypher1;
  assign c_arr[2] = bus.cypher2;
  assign c_arr[3] = bus.cypher3;
  assign v_vec    = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};

  // Reference model state
  logic [3:0] q [4][$];
  logic [3:0] exp_last [4];
  logic [3:0] exp_full;
  logic [1:0] exp_rr;
  logic [7:0] exp_total;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      exp_last[k] = 4'h0;
    end
    exp_full  = 4'b0;
    exp_rr    = 2'd0;
    exp_total = 8'd0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valids"}, int'(v_vec), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_cypher%0d", tag, k), int'(c_arr[k]), 0);
    chk({tag, "_rr_ptr"}, int'(bus.rr_ptr), 0);
    chk({tag, "_total"}, int'(bus.total_count), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
  endtask

  // Monitor: compare DUT outputs with the model, then consume on valid&ready
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [1:0] d;
      for (int k = 0; k < 4; k++) begin
        exp_full[k] = (q[k].size() == DEPTH);
        chk($sformatf("valid%0d", k), int'(v_vec[k]), int'(q[k].size() != 0));
        if (q[k].size() != 0)
          chk($sformatf("head%0d", k), int'(c_arr[k]), int'(q[k][0]));
        else
          chk($sformatf("hold%0d", k), int'(c_arr[k]), int'(exp_last[k]));
      end
      d = bus.auto_rr ? exp_rr : bus.s;
      chk("in_ready", int'(bus.in_ready), int'(!exp_full[d]));
      chk("rr_ptr", int'(bus.rr_ptr), int'(exp_rr));
      chk("total_count", int'(bus.total_count), int'(exp_total));
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() != 0 && r_vec[k]) exp_last[k] = q[k].pop_front();
      end
    end
  end

  // Stimulus
  initial begin
    int pr;
    logic [1:0] d;
    bus.cypher   = 4'h0;
    bus.s        = 2'd0;
    bus.auto_rr  = 1'b0;
    bus.in_valid = 1'b0;
    r_vec        = 4'b0;
    model_clear();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      case ((i / 150) % 4)
        0:       pr = 80;
        1:       pr = 15;
        2:       pr = 50;
        default: pr = 95;
      endcase
      bus.cypher   = 4'($urandom);
      bus.s        = 2'($urandom);
      bus.in_valid = ($urandom_range(99) < 70);
      if ($urandom_range(19) == 0) bus.auto_rr = ~bus.auto_rr;
      for (int k = 0; k < 4; k++) r_vec[k] = ($urandom_range(99) < pr);

      if (i == RST_AT) begin
        // Asynchronous reset mid-cycle with channels partly occupied
        #1 rst_n = 1'b0;
        #1 check_reset("mid");
        model_clear();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        @(negedge clk);
        #1;
        d = bus.auto_rr ? exp_rr : bus.s;
        if (bus.in_valid && !exp_full[d]) begin
          q[d].push_back(bus.cypher);
          exp_total = exp_total + 8'd1;
          if (bus.auto_rr) exp_rr = exp_rr + 2'd1;
        end
      end
    end

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cypher_demux_1x4.md
CYPHER_DEMUX_1X4 -- requirements
Module: cypher_demux_1x4

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning per-channel FIFO depth in entries; a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cypher, input, 4 bits: inbound cypher nibble.
REQ-005 SHALL have port s, input, 2 bits: destination channel select, 0..3.
REQ-006 SHALL have port auto_rr, input, 1 bit: 1 selects round-robin destination and ignores s.
REQ-007 SHALL have port in_valid, input, 1 bit: inbound nibble present.
REQ-008 SHALL have port in_ready, output, 1 bit: destination channel can accept.
REQ-009 SHALL have ports cypher0..cypher3, output, 4 bits each: head entry of channel k.
REQ-010 SHALL have ports valid0..valid3, output, 1 bit each: channel k non-empty.
REQ-011 SHALL have ports ready0..ready3, input, 1 bit each: consumer of channel k accepts.
REQ-012 SHALL have port rr_ptr, output, 2 bits: current round-robin destination.
REQ-013 SHALL have port total_count, output, 8 bits: accepted-nibble counter.

Function
REQ-014 SHALL compute destination d = rr_ptr when auto_rr=1, else d = s.
REQ-015 SHALL drive in_ready = NOT full[d], combinationally from registered full flags and d; no full-bypass.
REQ-016 SHALL push cypher into FIFO d on a rising edge where in_valid=1 and in_ready=1; only FIFO d changes on that edge.
REQ-017 SHALL implement each channel as a first-word-fall-through FIFO: validk=1 iff channel k is non-empty, and cypherk = oldest entry.
REQ-018 SHALL pop channel k on a rising edge where validk=1 and readyk=1.
REQ-019 SHALL have push-to-output latency of 1 cycle: a nibble pushed into an empty channel appears on cypherk/validk after that edge.
REQ-020 SHALL on a simultaneous push and pop of the same non-full channel keep occupancy unchanged and preserve FIFO order.
REQ-021 SHALL on a pop of a full channel assert in_ready for that channel from the next cycle, not the same cycle.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH; the full/empty distinction SHALL use one extra pointer bit or an occupancy counter.
REQ-023 SHALL hold cypherk at its last value while validk=0; consumers treat it as don't-care.
REQ-024 SHALL increment rr_ptr by 1 on each accepted nibble while auto_rr=1, wrapping 3 to 0.
REQ-025 SHALL hold rr_ptr when auto_rr=0 or no nibble is accepted; toggling auto_rr does not reset rr_ptr.
REQ-026 SHALL stall round-robin at a full channel: in_ready=0, with no skip to another channel.
REQ-027 SHALL increment total_count on each accepted nibble, wrapping 255 to 0.
REQ-028 SHALL treat in_valid=1 with in_ready=0 as backpressure: no state change and no error.
REQ-029 SHALL leave channels independent: pops on any channels may occur in the same cycle as a push to another channel.

Reset
REQ-030 SHALL on rst_n=0, immediately and independently of clk, empty all FIFOs, drive valid0..3=0 and cypher0..3=4'h0, and clear rr_ptr and total_count to 0.
REQ-031 SHALL drive in_ready=1 during and after reset, since all channels are empty.
REQ-032 SHALL discard all buffered data when reset is asserted mid-operation; first activity after deassertion behaves as from power-up.

Verification
REQ-033 Directed: auto_rr=0, s=2, push 4'hA, ready2=0 -> next cycle valid2=1, cypher2=A; other valids 0; total_count=1.
REQ-034 Directed: DEPTH=2, s=1, ready1=0, push 3,5,7 -> 3 and 5 accepted, in_ready=0 while offering 7; set ready1=1 -> pops 3, in_ready=1 the next cycle, then 7 accepted.
REQ-035 Directed: auto_rr=1, all readyk=1, push 1,2,3,4,5 -> nibbles land on channels 0,1,2,3,0; rr_ptr sequence 0,1,2,3,0,1.
REQ-036 Directed: channel 0 holding one entry, simultaneous push 9 and pop -> occupancy stays 1, next head=9, order preserved.
REQ-037 Directed: 256 accepted nibbles -> total_count wraps to 0.
REQ-038 Directed: rst_n pulled low mid-stream with channels partially full -> valid0..3=0 and rr_ptr=0 before the next clk edge, in_ready=1.
